// File: rtl/single_port_ram_ctrl.sv
// -----------------------------------------------------------------------------
// single_port_ram_ctrl
//
// Purpose:
//   Single-port word RAM with byte-enable writes. After every reset the block
//   walks the whole array writing zeros (CLEAR state, one word per cycle),
//   then accepts one read or write per cycle (IDLE state). Every accepted
//   access, read or write, returns exactly one word on data_out with a
//   rd_valid pulse, in acceptance order.
//
// Parameters:
//   DATA_WIDTH - word width in bits (multiple of 8)
//   ADDR_WIDTH - word address width, DEPTH = 2**ADDR_WIDTH
//   READ_MODE  - data returned for a write: 0 = old word, 1 = merged new word
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   req      in   access request
//   ready    out  access can be accepted this cycle (inverse of busy)
//   write_en in   1 = write, 0 = read
//   byte_en  in   per-byte write enables
//   addr     in   word address
//   data_in  in   write data
//   data_out out  returned word, held while rd_valid is low
//   rd_valid out  data_out valid this cycle
//   busy     out  clear sequence in progress
//
// Configuration:
//   SINGLE_PORT_RAM_CTRL_OUT_REG_EN - when defined, adds an output register
//   stage (return latency 2 instead of 1); throughput is unchanged.
// -----------------------------------------------------------------------------
module single_port_ram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int READ_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  output logic                    ready,
  input  logic                    write_en,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    busy_q, busy_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Access acceptance and the byte-merged write word built from the old word.
  always_comb begin
    accept      = req && (state_q == IDLE);
    rd_word     = mem[addr];
    merged_word = rd_word;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (byte_en[b]) begin
        merged_word[b*8 +: 8] = data_in[b*8 +: 8];
      end
    end
  end

  // Next-state logic. The clear counter stops at DEPTH-1 once IDLE is
  // reached and only returns to 0 through reset.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = merged_word;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        if (clr_cnt_q == '1) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        mem_we = accept && write_en && (|byte_en);
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    busy_d     = (state_d == CLEAR);
    s1_valid_d = accept;
    // A write returns the merged word only in write-first mode; with all
    // byte enables low the merged word equals the old word anyway.
    if (accept) begin
      s1_data_d = (write_en && (READ_MODE == 1)) ? merged_word : rd_word;
    end else begin
      s1_data_d = s1_data_q;
    end
  end

  // FSM, clear counter, registered busy and first return stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      busy_q     <= busy_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  // Array write port; contents are never reset, only overwritten by CLEAR.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busy  = busy_q;
  assign ready = ~busy_q;

`ifdef SINGLE_PORT_RAM_CTRL_OUT_REG_EN
  logic                  s2_valid_q;
  logic [DATA_WIDTH-1:0] s2_data_q;
  logic [DATA_WIDTH-1:0] s2_data_d;

  // Second stage only reloads on a valid word so data_out holds otherwise.
  always_comb begin
    s2_data_d = s1_valid_q ? s1_data_q : s2_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= s2_data_d;
    end
  end

  assign data_out = s2_data_q;
  assign rd_valid = s2_valid_q;
`else
  assign data_out = s1_data_q;
  assign rd_valid = s1_valid_q;
`endif

endmodule

// File: tb/tb_single_port_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_single_port_ram_ctrl
//
// Two instances share all inputs: dut0 is read-first, dut1 is write-first.
// A behavioural model (array + pending-return queue) predicts busy, rd_valid
// and data_out for both after every clock edge.
// -----------------------------------------------------------------------------
module tb_single_port_ram_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NB    = DW / 8;
`ifdef SINGLE_PORT_RAM_CTRL_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          write_en = 1'b0;
  logic [NB-1:0] byte_en = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;

  logic          ready0, rd_valid0, busy0;
  logic [DW-1:0] data_out0;
  logic          ready1, rd_valid1, busy1;
  logic [DW-1:0] data_out1;

  always #5 clk = ~clk;

  single_port_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .ready(ready0), .write_en(write_en),
    .byte_en(byte_en), .addr(addr), .data_in(data_in), .data_out(data_out0),
    .rd_valid(rd_valid0), .busy(busy0)
  );

  single_port_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .ready(ready1), .write_en(write_en),
    .byte_en(byte_en), .addr(addr), .data_in(data_in), .data_out(data_out1),
    .rd_valid(rd_valid1), .busy(busy1)
  );

  // Reference model state
  typedef struct {
    int          due;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } pend_t;

  logic [DW-1:0] ref_mem [DEPTH];
  pend_t         pq[$];
  int            clear_left;
  int            cyc;
  logic          exp_busy;
  logic          exp_valid;
  logic [DW-1:0] exp_d0, exp_d1;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic model_reset();
    pq.delete();
    clear_left = DEPTH;
    exp_busy   = 1'b1;
    exp_valid  = 1'b0;
    exp_d0     = '0;
    exp_d1     = '0;
  endtask

  // One clock edge: update the model from the inputs present before the
  // edge, then move to the sampling point 1 time unit after the edge.
  task automatic tick();
    bit            acc;
    logic [DW-1:0] old_w, new_w;
    pend_t         p;
    acc = req && !rst && (clear_left == 0);
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end else if (acc) begin
      old_w = ref_mem[addr];
      new_w = old_w;
      if (write_en) begin
        for (int b = 0; b < NB; b++) begin
          if (byte_en[b]) new_w[b*8 +: 8] = data_in[b*8 +: 8];
        end
        ref_mem[addr] = new_w;
      end
      p.due = cyc + LAT - 1;
      p.d0  = old_w;
      p.d1  = new_w;
      pq.push_back(p);
    end
    exp_busy  = (clear_left > 0);
    exp_valid = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      exp_valid = 1'b1;
      exp_d0    = pq[0].d0;
      exp_d1    = pq[0].d1;
      void'(pq.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    int edges;
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    n_vec++;
    if ({busy0, ready0, rd_valid0, data_out0, busy1, ready1, rd_valid1, data_out1} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("[TB] FAIL reset_state got b/r/v=%b%b%b d=%h, %b%b%b d=%h want 100 d=0",
               busy0, ready0, rd_valid0, data_out0, busy1, ready1, rd_valid1, data_out1);
    end
    rst = 1'b0;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      edges++;
      n_vec++;
      if ({busy0, ready0, rd_valid0, busy1, ready1, rd_valid1} !==
          {exp_busy, !exp_busy, exp_valid, exp_busy, !exp_busy, exp_valid}) begin
        n_err++;
        $display("[TB] FAIL clear_walk cyc=%0d got b/r/v=%b%b%b,%b%b%b want busy=%b valid=%b",
                 cyc, busy0, ready0, rd_valid0, busy1, ready1, rd_valid1, exp_busy, exp_valid);
      end
      if (!busy0) break;
    end
    n_vec++;
    if (edges != DEPTH || ready0 !== 1'b1 || ready1 !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL clear_length got %0d cycles ready=%b%b want %0d cycles ready=11",
               edges, ready0, ready1, DEPTH);
    end
  endtask

  task automatic test_clear_reads();
    int seen;
    seen = 0;
    for (int i = 0; i < DEPTH + LAT + 1; i++) begin
      req      = (i < DEPTH);
      write_en = 1'b0;
      addr     = AW'(i);
      tick();
      n_vec++;
      if ({busy0, rd_valid0, data_out0, busy1, rd_valid1, data_out1} !==
          {exp_busy, exp_valid, exp_d0, exp_busy, exp_valid, exp_d1}) begin
        n_err++;
        $display("[TB] FAIL clear_reads cyc=%0d got v=%b%b d=%h,%h want v=%b d=%h,%h",
                 cyc, rd_valid0, rd_valid1, data_out0, data_out1, exp_valid, exp_d0, exp_d1);
      end
      if (rd_valid0 === 1'b1 && data_out0 === 32'h0) seen++;
    end
    n_vec++;
    if (seen != DEPTH) begin
      n_err++;
      $display("[TB] FAIL clear_zero got %0d zero words want %0d", seen, DEPTH);
    end
  endtask

  task automatic test_byte_enable();
    int acc_cyc, val_cyc;
    logic [DW-1:0] got;
    acc_cyc = -1;
    val_cyc = -1;
    got     = 'x;
    for (int i = 0; i < 3 + LAT + 1; i++) begin
      req = (i < 3);
      case (i)
        0: begin write_en = 1'b1; byte_en = 4'b1111; addr = 4'd3; data_in = 32'hAABBCCDD; end
        1: begin write_en = 1'b1; byte_en = 4'b0101; addr = 4'd3; data_in = 32'h11223344; end
        default: begin write_en = 1'b0; byte_en = 4'b0000; addr = 4'd3; end
      endcase
      tick();
      if (i == 2) acc_cyc = cyc;
      if (i >= 2 && rd_valid0 === 1'b1 && val_cyc < 0) begin
        val_cyc = cyc;
        got     = data_out0;
      end
      n_vec++;
      if ({rd_valid0, data_out0, rd_valid1, data_out1} !==
          {exp_valid, exp_d0, exp_valid, exp_d1}) begin
        n_err++;
        $display("[TB] FAIL byte_en_seq cyc=%0d got v=%b%b d=%h,%h want v=%b d=%h,%h",
                 cyc, rd_valid0, rd_valid1, data_out0, data_out1, exp_valid, exp_d0, exp_d1);
      end
    end
    n_vec++;
    if (got !== 32'hAA22CC44 || val_cyc != acc_cyc + LAT - 1) begin
      n_err++;
      $display("[TB] FAIL byte_en_read got %h at +%0d want aa22cc44 at +%0d",
               got, val_cyc - acc_cyc + 1, LAT);
    end
  endtask

  task automatic test_read_mode();
    logic [DW-1:0] g0, g1;
    g0 = 'x;
    g1 = 'x;
    for (int i = 0; i < 2 + LAT + 1; i++) begin
      req      = (i < 2);
      write_en = 1'b1;
      byte_en  = 4'b1111;
      addr     = 4'd5;
      data_in  = (i == 0) ? 32'h1 : 32'h2;
      tick();
      if (i == LAT) begin
        g0 = data_out0;
        g1 = data_out1;
      end
      n_vec++;
      if ({rd_valid0, data_out0, rd_valid1, data_out1} !==
          {exp_valid, exp_d0, exp_valid, exp_d1}) begin
        n_err++;
        $display("[TB] FAIL read_mode_seq cyc=%0d got v=%b%b d=%h,%h want v=%b d=%h,%h",
                 cyc, rd_valid0, rd_valid1, data_out0, data_out1, exp_valid, exp_d0, exp_d1);
      end
    end
    n_vec++;
    if (g0 !== 32'h1 || g1 !== 32'h2) begin
      n_err++;
      $display("[TB] FAIL read_mode got rf=%h wf=%h want rf=1 wf=2", g0, g1);
    end
  endtask

  task automatic test_back_to_back();
    int first_v, last_v, k;
    logic [DW-1:0] got [8];
    for (int i = 0; i < 8 + LAT + 1; i++) begin
      req      = (i < 8);
      write_en = 1'b1;
      byte_en  = 4'b1111;
      addr     = AW'(i);
      data_in  = DW'(i);
      tick();
      n_vec++;
      if ({rd_valid0, data_out0, rd_valid1, data_out1} !==
          {exp_valid, exp_d0, exp_valid, exp_d1}) begin
        n_err++;
        $display("[TB] FAIL b2b_preload cyc=%0d got v=%b%b d=%h,%h want v=%b d=%h,%h",
                 cyc, rd_valid0, rd_valid1, data_out0, data_out1, exp_valid, exp_d0, exp_d1);
      end
    end
    first_v = -1;
    last_v  = -1;
    k       = 0;
    for (int i = 0; i < 8 + LAT + 1; i++) begin
      req      = (i < 8);
      write_en = 1'b0;
      addr     = AW'(i);
      tick();
      if (rd_valid0 === 1'b1 && rd_valid1 === 1'b1) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        if (k < 8) got[k] = data_out0;
        k++;
      end
    end
    n_vec++;
    if (k != 8 || last_v - first_v != 7 || first_v != LAT - 1) begin
      n_err++;
      $display("[TB] FAIL b2b_stream got %0d valids span %0d first %0d want 8 span 7 first %0d",
               k, last_v - first_v, first_v, LAT - 1);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (got[i] !== DW'(i)) begin
        n_err++;
        $display("[TB] FAIL b2b_data[%0d] got %h want %h", i, got[i], DW'(i));
      end
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_ignored();
    int nv;
    logic [DW-1:0] got;
    nv  = 0;
    got = 'x;
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      req      = 1'b1;
      write_en = 1'b1;
      byte_en  = 4'b1111;
      addr     = 4'd2;
      data_in  = 32'hFF;
      tick();
      if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) nv++;
    end
    for (int i = 0; i < LAT + 1; i++) begin
      req      = (i == 0);
      write_en = 1'b0;
      tick();
      if (rd_valid0 === 1'b1) got = data_out0;
    end
    n_vec++;
    if (nv != 0 || got !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL ignored_req got %0d valids in clear, read %h want 0 valids, read 0",
               nv, got);
    end
  endtask

  task automatic test_mid_reset();
    int nv, edges;
    logic [DW-1:0] g_lo, g_hi;
    for (int i = 0; i < 2 + LAT + 1; i++) begin
      req      = (i < 2);
      write_en = 1'b1;
      byte_en  = 4'b1111;
      addr     = (i == 0) ? 4'd0 : 4'd15;
      data_in  = 32'h5A5A_1234;
      tick();
    end
    req      = 1'b1;
    write_en = 1'b0;
    addr     = 4'd0;
    tick();
    nv = (LAT == 1) ? 0 : int'(rd_valid0 | rd_valid1);
    req = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({busy0, ready0, rd_valid0, data_out0, busy1, ready1, rd_valid1, data_out1} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("[TB] FAIL mid_reset_now got b/r/v=%b%b%b d=%h, %b%b%b d=%h want 100 d=0",
               busy0, ready0, rd_valid0, data_out0, busy1, ready1, rd_valid1, data_out1);
    end
    tick();
    rst   = 1'b0;
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      edges++;
      if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) nv++;
      if (!busy0) break;
    end
    n_vec++;
    if (nv != 0 || edges != DEPTH) begin
      n_err++;
      $display("[TB] FAIL mid_reset_clear got %0d valids, %0d clear cycles want 0, %0d",
               nv, edges, DEPTH);
    end
    g_lo = 'x;
    g_hi = 'x;
    for (int i = 0; i < 2 + LAT + 1; i++) begin
      req      = (i < 2);
      write_en = 1'b0;
      addr     = (i == 0) ? 4'd0 : 4'd15;
      tick();
      if (i == LAT - 1) g_lo = data_out0;
      if (i == LAT)     g_hi = data_out0;
    end
    n_vec++;
    if (g_lo !== 32'h0 || g_hi !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL mid_reset_zero got addr0=%h addr15=%h want 0,0", g_lo, g_hi);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300 + LAT + 1; i++) begin
      req      = (i < 300) && ($urandom_range(3) != 0);
      write_en = $urandom_range(1);
      byte_en  = NB'($urandom);
      addr     = AW'($urandom);
      data_in  = $urandom;
      tick();
      n_vec++;
      if ({busy0, ready0, rd_valid0, data_out0, busy1, ready1, rd_valid1, data_out1} !==
          {exp_busy, !exp_busy, exp_valid, exp_d0, exp_busy, !exp_busy, exp_valid, exp_d1}) begin
        n_err++;
        $display("[TB] FAIL random cyc=%0d got b/r/v=%b%b%b,%b%b%b d=%h,%h want busy=%b v=%b d=%h,%h",
                 cyc, busy0, ready0, rd_valid0, busy1, ready1, rd_valid1, data_out0, data_out1,
                 exp_busy, exp_valid, exp_d0, exp_d1);
      end
    end
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_reset();
    test_reset();
    test_clear_reads();
    test_byte_enable();
    test_read_mode();
    test_back_to_back();
    test_ignored();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/single_port_ram_ctrl.md
SINGLE_PORT_RAM_CTRL -- requirements
Module: single_port_ram_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data word width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, giving the address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter READ_MODE, default 0, selecting read data on writes: 0 = read-first (old word), 1 = write-first (merged new word).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port req, input, 1 bit: access request.
REQ-007 The block SHALL have port ready, output, 1 bit: the block can accept an access this cycle.
REQ-008 The block SHALL have port write_en, input, 1 bit: the access is a write when high and a read when low.
REQ-009 The block SHALL have port byte_en, input, DATA_WIDTH/8 bits: per-byte write enables.
REQ-010 The block SHALL have port addr, input, ADDR_WIDTH bits: word address.
REQ-011 The block SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-012 The block SHALL have port data_out, output, DATA_WIDTH bits: read data.
REQ-013 The block SHALL have port rd_valid, output, 1 bit: data_out is valid this cycle.
REQ-014 The block SHALL have port busy, output, 1 bit: the block is in the clear sequence.

Function
REQ-015 The FSM SHALL have exactly two states, CLEAR and IDLE; reset enters CLEAR.
REQ-016 In CLEAR, the block SHALL write all-zero to the address held by a clear counter each cycle, starting at 0 and incrementing by 1.
REQ-017 When the clear counter equals DEPTH-1, the block SHALL perform that final write and move to IDLE on the same edge; CLEAR therefore lasts exactly DEPTH cycles.
REQ-018 busy SHALL be high exactly in CLEAR; ready SHALL be the inverse of busy.
REQ-019 An access SHALL be accepted on an edge where req=1 and ready=1; req while ready=0 SHALL be ignored, with no memory change and no rd_valid.
REQ-020 An accepted write SHALL update only the bytes whose byte_en bit is 1; a write with byte_en all-zero SHALL leave memory unchanged.
REQ-021 Every accepted access, read or write, SHALL produce exactly one rd_valid pulse, with data_out returned with latency L after acceptance.
REQ-022 For an accepted write, data_out SHALL be the pre-write word when READ_MODE=0 and the post-merge word when READ_MODE=1.
REQ-023 Back-to-back accesses every cycle SHALL be supported at full throughput, with results returned in acceptance order.
REQ-024 A read of the address written by the previous access SHALL return the updated word.
REQ-025 data_out SHALL hold its last value while rd_valid=0.
REQ-026 The address SHALL not wrap: addr covers exactly DEPTH words, and the clear counter SHALL wrap to 0 only on the next reset.

Reset
REQ-027 Assertion of rst SHALL immediately force state CLEAR, clear counter 0, busy=1, ready=0, rd_valid=0 (including all pipeline valids), and data_out=0.
REQ-028 An rst asserted mid-clear or mid-access SHALL abort any in-flight access without a rd_valid pulse and restart clearing at address 0 after deassertion.
REQ-029 Memory contents SHALL NOT be reset asynchronously; they are zeroed only by the CLEAR sequence.

Configuration
REQ-030 With macro SINGLE_PORT_RAM_CTRL_OUT_REG_EN defined, an extra output register stage SHALL be inserted, making L=2 with rd_valid delayed identically.
REQ-031 With SINGLE_PORT_RAM_CTRL_OUT_REG_EN undefined, L SHALL be 1: data_out and rd_valid are registered directly from the array read.
REQ-032 With SINGLE_PORT_RAM_CTRL_OUT_REG_EN defined, the extra stage SHALL reset to data_out=0 and rd_valid=0.
REQ-033 All other behaviour, including throughput, SHALL be identical with and without the macro.

Verification
REQ-034 Verification SHALL cover clear-on-reset: release rst with ADDR_WIDTH=4 -> busy high exactly 16 cycles, then ready=1; reading addresses 0..15 returns 0x00000000.
REQ-035 Verification SHALL cover byte-enable write: write 0xAABBCCDD to addr 3 with byte_en=4'b1111, then 0x11223344 with byte_en=4'b0101 -> a read of addr 3 returns 0xAA22CC44, with rd_valid L cycles after acceptance.
REQ-036 Verification SHALL cover read mode: addr 5 holds 0x1; write 0x2 with all byte_en -> write-return data_out=0x1 with READ_MODE=0 and 0x2 with READ_MODE=1.
REQ-037 Verification SHALL cover throughput: 8 consecutive accepted reads of addresses 0..7 preloaded with value=addr -> 8 consecutive rd_valid cycles, data 0..7 in order, for both L=1 and L=2.
REQ-038 Verification SHALL cover the ignored request: req=1 during CLEAR with a write of 0xFF to addr 2 -> after clear, a read of addr 2 returns 0, and no rd_valid occurs during CLEAR.
REQ-039 Verification SHALL cover mid-operation reset: assert rst one cycle after accepting a read -> rd_valid never pulses, data_out=0, busy=1 immediately, and the clear restarts at address 0.
